// File: rtl/iact_addr_stream_gen_if.sv
// Handshake bundle between the column-count source, iact_addr_stream_gen and the address SRAM.
// The master modport is the generator's view; slave is the surrounding source/SRAM view.
interface iact_addr_stream_gen_if #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 4
);
    logic              cnt_valid;
    logic              cnt_ready;
    logic [CNT_W-1:0]  cnt;
    logic              col_last;
    logic              batch_last;
    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr_out;
    logic              write_en;
    logic              write_done;

    modport master (
        input  cnt_valid,
        input  cnt,
        input  col_last,
        input  batch_last,
        input  addr_ready,
        input  write_done,
        output cnt_ready,
        output addr_valid,
        output addr_out,
        output write_en
    );

    modport slave (
        output cnt_valid,
        output cnt,
        output col_last,
        output batch_last,
        output addr_ready,
        output write_done,
        input  cnt_ready,
        input  addr_valid,
        input  addr_out,
        input  write_en
    );
endinterface

// File: rtl/iact_addr_stream_gen.sv
// Turns per-column nonzero counts into cumulative CSC address words, closing each stream with a 0
// terminator and each batch with a second 0. Optional sticky err flag: define IACT_ADDR_GEN_ERR_EN.
module iact_addr_stream_gen #(
    parameter int ADDR_W      = 7,
    parameter int CNT_W       = 4,
    parameter int MAX_STREAMS = 31,
    parameter int EMPTY_CODE  = 127
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    iact_addr_stream_gen_if.master stream_if,
    output logic                  busy_o,
    output logic                  err_o
);
    // One extra count bit so the counter never wraps on the forced-end stream.
    localparam int SC_W = $clog2(MAX_STREAMS + 2);
    localparam logic [ADDR_W:0]   SAT_EXT    = (ADDR_W+1)'((1 << ADDR_W) - 2);
    localparam logic [ADDR_W-1:0] EMPTY_WORD = ADDR_W'(EMPTY_CODE);
    localparam logic [SC_W-1:0]   MAX_SC     = SC_W'(MAX_STREAMS);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        TERM1,
        TERM2,
        WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cum_q, cum_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic              addr_valid_q, addr_valid_d;
    logic [SC_W-1:0]   stream_cnt_q, stream_cnt_d;
    logic              force_end_q, force_end_d;

    logic [ADDR_W:0]   sum_ext;
    logic [ADDR_W-1:0] new_cum;
    logic              overflow;
    logic              out_free;
    logic              cnt_ready;
    logic              cnt_fire;
    logic              stream_limit;

    // The output register can take a new word when empty or when its word leaves this cycle.
    assign out_free     = ~addr_valid_q | stream_if.addr_ready;
    assign cnt_ready    = (state_q == ACCUM) & out_free;
    assign cnt_fire     = stream_if.cnt_valid & cnt_ready;
    assign sum_ext      = {1'b0, cum_q} + (ADDR_W+1)'(stream_if.cnt);
    assign overflow     = sum_ext > SAT_EXT;
    assign new_cum      = overflow ? SAT_EXT[ADDR_W-1:0] : sum_ext[ADDR_W-1:0];
    assign stream_limit = (stream_cnt_q == MAX_SC);

    assign stream_if.cnt_ready  = cnt_ready;
    assign stream_if.addr_valid = addr_valid_q;
    assign stream_if.addr_out   = addr_out_q;
    assign stream_if.write_en   = (state_q != IDLE);
    assign busy_o               = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        cum_d        = cum_q;
        addr_out_d   = addr_out_q;
        addr_valid_d = addr_valid_q & ~stream_if.addr_ready;
        stream_cnt_d = stream_cnt_q;
        force_end_d  = force_end_q;

        case (state_q)
            IDLE: begin
                if (stream_if.cnt_valid) begin
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                if (cnt_fire) begin
                    cum_d        = new_cum;
                    // 0 is reserved for terminators, so an empty leading column gets its own code.
                    addr_out_d   = (new_cum == '0) ? EMPTY_WORD : new_cum;
                    addr_valid_d = 1'b1;
                    if (stream_if.col_last) begin
                        state_d     = TERM1;
                        force_end_d = stream_if.batch_last | stream_limit;
                    end
                end
            end

            TERM1: begin
                if (out_free) begin
                    addr_out_d   = '0;
                    addr_valid_d = 1'b1;
                    cum_d        = '0;
                    stream_cnt_d = stream_cnt_q + SC_W'(1);
                    state_d      = force_end_q ? TERM2 : ACCUM;
                end
            end

            TERM2: begin
                if (out_free) begin
                    addr_out_d   = '0;
                    addr_valid_d = 1'b1;
                    state_d      = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (stream_if.write_done) begin
                    state_d      = IDLE;
                    stream_cnt_d = '0;
                    force_end_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            cum_q        <= '0;
            addr_out_q   <= '0;
            addr_valid_q <= 1'b0;
            stream_cnt_q <= '0;
            force_end_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cum_q        <= cum_d;
            addr_out_q   <= addr_out_d;
            addr_valid_q <= addr_valid_d;
            stream_cnt_q <= stream_cnt_d;
            force_end_q  <= force_end_d;
        end
    end

`ifdef IACT_ADDR_GEN_ERR_EN
    logic err_q;
    logic err_set;

    // Flags a saturated sum or a stream closed on the last LUT slot.
    assign err_set = cnt_fire & (overflow | (stream_if.col_last & stream_limit));

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_iact_addr_stream_gen.sv
// Bench for iact_addr_stream_gen: directed scenarios plus random batches against a word-list model.
`timescale 1ns/1ps
module tb_iact_addr_stream_gen;
    localparam int ADDR_W      = 7;
    localparam int CNT_W       = 4;
    localparam int MAX_STREAMS = 31;
    localparam int EMPTY_CODE  = 127;
    localparam int SAT         = 126;
`ifdef IACT_ADDR_GEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] c;
        logic             cl;
        logic             bl;
    } col_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err;

    iact_addr_stream_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) sif ();

    iact_addr_stream_gen #(
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W),
        .MAX_STREAMS(MAX_STREAMS),
        .EMPTY_CODE (EMPTY_CODE)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .stream_if(sif),
        .busy_o   (busy),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    int   n_cmp      = 0;
    int   n_err      = 0;
    int   exp_q[$];
    col_t batch_q[$];
    int   ready_mode = 0;
    int   gap_max    = 0;
    int   last_wait  = 0;
    int   n_words    = 0;
    bit   err_exp    = 1'b0;
    bit   hold_pend  = 1'b0;
    logic [ADDR_W-1:0] held_word = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // addr_ready driver: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        sif.addr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       sif.addr_ready = 1'b1;
                1:       sif.addr_ready = ($urandom_range(0, 3) != 0);
                default: sif.addr_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: every accepted word is compared in order; stalled words must not move.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check_eq("hold_valid", 32'(sif.addr_valid), 1);
                    check_eq("hold_data", 32'(sif.addr_out), 32'(held_word));
                end
                if (sif.addr_valid && sif.addr_ready) begin
                    n_words++;
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", 32'(sif.addr_out), 32'hFFFF_FFFF);
                    end else begin
                        check_eq($sformatf("word%0d", n_words), 32'(sif.addr_out), 32'(exp_q.pop_front()));
                    end
                end
                hold_pend = sif.addr_valid && !sif.addr_ready;
                held_word = sif.addr_out;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: cumulative sums per stream, 0 after each stream, extra 0 at batch end.
    task automatic model_batch();
        int cum = 0;
        int k   = 1;
        foreach (batch_q[i]) begin
            int s = cum + int'(batch_q[i].c);
            if (s > SAT) begin
                err_exp = 1'b1;
                s = SAT;
            end
            cum = s;
            exp_q.push_back(cum == 0 ? EMPTY_CODE : cum);
            if (batch_q[i].cl) begin
                exp_q.push_back(0);
                if (k == MAX_STREAMS + 1) err_exp = 1'b1;
                if (batch_q[i].bl || k == MAX_STREAMS + 1) exp_q.push_back(0);
                cum = 0;
                k++;
            end
        end
    endtask

    task automatic send_col(input col_t c);
        int waited = 0;
        sif.cnt_valid  = 1'b1;
        sif.cnt        = c.c;
        sif.col_last   = c.cl;
        sif.batch_last = c.bl;
        forever begin
            @(negedge clk);
            if (sif.cnt_ready) break;
            waited++;
            if (waited > 300) begin
                check_eq("cnt_accept", 32'(sif.cnt_ready), 1);
                break;
            end
        end
        last_wait = waited;
        @(posedge clk);
        #1;
        sif.cnt_valid  = 1'b0;
        sif.col_last   = 1'b0;
        sif.batch_last = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_batch();
        foreach (batch_q[i]) send_col(batch_q[i]);
    endtask

    task automatic add_col(input int c, input bit cl, input bit bl);
        col_t e;
        e.c  = CNT_W'(c);
        e.cl = cl;
        e.bl = bl;
        batch_q.push_back(e);
    endtask

    task automatic finish_batch(input string tag);
        int t = 0;
        while ((exp_q.size() != 0 || sif.addr_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 0);
        @(negedge clk);
        check_eq({tag, "_busy_wait"}, 32'(busy), 1);
        check_eq({tag, "_cnt_ready_wait"}, 32'(sif.cnt_ready), 0);
        check_eq({tag, "_err"}, 32'(err), 32'(err_exp & ERR_EN));
        @(posedge clk);
        #1;
        sif.write_done = 1'b1;
        @(posedge clk);
        #1;
        sif.write_done = 1'b0;
        @(negedge clk);
        check_eq({tag, "_busy_idle"}, 32'(busy), 0);
        check_eq({tag, "_we_idle"}, 32'(sif.write_en), 0);
        $display("batch %s done: %0d words seen so far", tag, n_words);
    endtask

    task automatic gen_random_batch();
        int ns = $urandom_range(1, 4);
        batch_q.delete();
        for (int s = 0; s < ns; s++) begin
            int nc = $urandom_range(1, 6);
            for (int c = 0; c < nc; c++) begin
                int r = $urandom_range(0, 9);
                int v;
                if (r == 0)     v = 0;
                else if (r < 3) v = 15;
                else            v = $urandom_range(0, 15);
                add_col(v, c == nc - 1, (c == nc - 1) && (s == ns - 1));
            end
        end
    endtask

    initial begin
        int w0;
        col_t e;
        sif.cnt_valid  = 1'b0;
        sif.cnt        = '0;
        sif.col_last   = 1'b0;
        sif.batch_last = 1'b0;
        sif.write_done = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_cnt_ready", 32'(sif.cnt_ready), 0);
        check_eq("rst_addr_valid", 32'(sif.addr_valid), 0);
        check_eq("rst_addr_out", 32'(sif.addr_out), 0);
        check_eq("rst_write_en", 32'(sif.write_en), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // 3,0,2(last),4(last,batch) -> 3,3,5,0,4,0,0; write_done mid-batch is ignored
        ready_mode = 0;
        gap_max    = 0;
        exp_q      = '{3, 3, 5, 0, 4, 0, 0};
        e = '{c: 4'd3, cl: 1'b0, bl: 1'b0};
        send_col(e);
        check_eq("lat1_valid", 32'(sif.addr_valid), 1);
        check_eq("lat1_data", 32'(sif.addr_out), 3);
        e = '{c: 4'd0, cl: 1'b0, bl: 1'b0};
        send_col(e);
        check_eq("thru_wait0", 32'(last_wait), 0);
        e = '{c: 4'd2, cl: 1'b1, bl: 1'b0};
        send_col(e);
        check_eq("thru_wait1", 32'(last_wait), 0);
        sif.write_done = 1'b1;
        @(posedge clk);
        #1;
        sif.write_done = 1'b0;
        check_eq("wd_ignored_busy", 32'(busy), 1);
        e = '{c: 4'd4, cl: 1'b1, bl: 1'b1};
        send_col(e);
        finish_batch("dirA");

        // Leading empty column -> 127,2,0,0
        batch_q.delete();
        add_col(0, 0, 0);
        add_col(2, 1, 1);
        exp_q = '{127, 2, 0, 0};
        drive_batch();
        finish_batch("empty");

        // Saturation: 15 x9 -> ... 120,126,0,0
        batch_q.delete();
        for (int i = 0; i < 9; i++) add_col(15, i == 8, i == 8);
        exp_q = '{15, 30, 45, 60, 75, 90, 105, 120, 126, 0, 0};
        err_exp = 1'b1;
        drive_batch();
        finish_batch("sat");

        // Five-cycle stall on addr_ready in the middle of a stream
        batch_q.delete();
        for (int i = 0; i < 8; i++) add_col($urandom_range(0, 3), i == 7, i == 7);
        model_batch();
        fork
            drive_batch();
            begin
                repeat (3) begin @(posedge clk); #1; end
                @(negedge clk);
                ready_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    if (sif.addr_valid) check_eq("stall_cnt_ready", 32'(sif.cnt_ready), 0);
                end
                check_eq("stall_word_pending", 32'(sif.addr_valid), 1);
                ready_mode = 0;
            end
        join
        finish_batch("stall");

        // Reset while parked in TERM1 with an unconsumed word
        ready_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        e = '{c: 4'd5, cl: 1'b1, bl: 1'b0};
        send_col(e);
        @(negedge clk);
        check_eq("t1_write_en", 32'(sif.write_en), 1);
        check_eq("t1_cnt_ready", 32'(sif.cnt_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_write_en", 32'(sif.write_en), 0);
        check_eq("arst_addr_valid", 32'(sif.addr_valid), 0);
        check_eq("arst_addr_out", 32'(sif.addr_out), 0);
        check_eq("arst_cnt_ready", 32'(sif.cnt_ready), 0);
        check_eq("arst_err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        err_exp = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        repeat (2) begin @(posedge clk); #1; end
        batch_q.delete();
        add_col(4, 1, 1);
        exp_q = '{4, 0, 0};
        drive_batch();
        finish_batch("post_rst");

        // 32 single-column streams, no batch_last: last one forced to batch end
        ready_mode = 1;
        gap_max    = 1;
        batch_q.delete();
        for (int i = 0; i < MAX_STREAMS + 1; i++) add_col($urandom_range(1, 15), 1, 0);
        model_batch();
        w0 = n_words;
        drive_batch();
        finish_batch("forced");
        check_eq("forced_words", 32'(n_words - w0), 65);

        // Random batches
        gap_max = 2;
        for (int b = 0; b < 25; b++) begin
            ready_mode = (b % 3 == 0) ? 0 : 1;
            gen_random_batch();
            model_batch();
            drive_batch();
            finish_batch($sformatf("rnd%0d", b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
